fir_coeff_bank_ctrl: RTL and testbench

//  Upstream control stage for the 33-tap transposed FIR. It generates the

---
 rtl/fir_coeff_bank_ctrl.sv | 104 ++++++++++
 tb/tb_fir_coeff_bank_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_bank_ctrl.sv
// fir_coeff_bank_ctrl
// Control stage for the 33-tap transposed FIR. A free-running divider
// produces the one-cycle sample strobe that drives the FIR's iEnAcc input.
// The tap coefficients are held in two banks. The host writes the shadow
// bank. The shadow bank is copied into the active bank only at a sample
// boundary, so one FIR update never sees a mix of old and new coefficients.
module fir_coeff_bank_ctrl #(
    parameter int NUM_TAP = 33,
    parameter int COEFF_W = 16,
    parameter int ADDR_W  = 6,
    parameter int DIV     = 12
) (
    input  logic                       iClk_12M,
    input  logic                       iRsn,
    input  logic                       iCoeffWrEn,
    input  logic [ADDR_W-1:0]          iCoeffAddr,
    input  logic [COEFF_W-1:0]         iCoeffData,
    input  logic                       iCommit,
    output logic                       oCommitBusy,
    output logic                       oWrErr,
    output logic                       oEnSample,
    output logic [NUM_TAP*COEFF_W-1:0] oCoeffBus
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_TAP);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             en_sample_q, en_sample_d;
    logic                             wr_err_q, wr_err_d;
    logic [NUM_TAP-1:0][COEFF_W-1:0]  shadow_q, shadow_d;
    logic [NUM_TAP-1:0][COEFF_W-1:0]  active_q, active_d;
    logic                             addr_ok;
    logic                             wr_accept;

    // Divider: count 0..DIV-1 and raise the strobe in the cycle after DIV-1.
    always_comb begin
        cnt_d       = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        en_sample_d = (cnt_q == CNT_MAX);
    end

    // Host write port: accept in-range writes while no commit is pending.
    always_comb begin
        addr_ok   = ({1'b0, iCoeffAddr} < ADDR_LIM);
        wr_accept = iCoeffWrEn && (state_q == IDLE) && addr_ok;
        wr_err_d  = iCoeffWrEn && !wr_accept;
        shadow_d  = shadow_q;
        if (wr_accept) begin
            shadow_d[iCoeffAddr] = iCoeffData;
        end
    end

    // Commit FSM: hold a request until the strobe, then copy all taps at once.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                if (iCommit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (en_sample_q) begin
                    active_d = shadow_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            en_sample_q <= 1'b0;
            wr_err_q    <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_sample_q <= en_sample_d;
            wr_err_q    <= wr_err_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    assign oCommitBusy = (state_q == PENDING);
    assign oWrErr      = wr_err_q;
    assign oEnSample   = en_sample_q;
    assign oCoeffBus   = active_q;

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// tb_fir_coeff_bank_ctrl
// Directed scenarios followed by random traffic. A cycle-level reference
// model tracks the cycle index since reset, the shadow and active banks,
// and the pending request. It checks every output on every cycle.
`timescale 1ns/1ps
module tb_fir_coeff_bank_ctrl;

    localparam int NUM_TAP = 33;
    localparam int COEFF_W = 16;
    localparam int ADDR_W  = 6;
    localparam int DIV     = 12;
    localparam int BUS_W   = NUM_TAP * COEFF_W;

    logic                iClk_12M;
    logic                iRsn;
    logic                iCoeffWrEn;
    logic [ADDR_W-1:0]   iCoeffAddr;
    logic [COEFF_W-1:0]  iCoeffData;
    logic                iCommit;
    logic                oCommitBusy;
    logic                oWrErr;
    logic                oEnSample;
    logic [BUS_W-1:0]    oCoeffBus;

    int unsigned assert_count = 0;
    int unsigned fail_count   = 0;

    logic [COEFF_W-1:0]  m_shadow [NUM_TAP];
    logic [COEFF_W-1:0]  m_active [NUM_TAP];
    bit                  m_pending;
    bit                  m_err;
    int                  m_cycle;
    int                  m_first_strobe;

    fir_coeff_bank_ctrl #(
        .NUM_TAP (NUM_TAP),
        .COEFF_W (COEFF_W),
        .ADDR_W  (ADDR_W),
        .DIV     (DIV)
    ) dut (
        .iClk_12M    (iClk_12M),
        .iRsn        (iRsn),
        .iCoeffWrEn  (iCoeffWrEn),
        .iCoeffAddr  (iCoeffAddr),
        .iCoeffData  (iCoeffData),
        .iCommit     (iCommit),
        .oCommitBusy (oCommitBusy),
        .oWrErr      (oWrErr),
        .oEnSample   (oEnSample),
        .oCoeffBus   (oCoeffBus)
    );

    // 12 MHz-style free-running clock
    initial begin
        iClk_12M = 1'b0;
        forever #5 iClk_12M = ~iClk_12M;
    end

    // Cycle n (1 = first cycle after reset release) carries a strobe when
    // (n-1) is a positive multiple of DIV.
    function automatic bit strobeAt(input int n);
        return (n >= 2) && (((n - 1) % DIV) == 0);
    endfunction

    function automatic logic [BUS_W-1:0] packActive();
        logic [BUS_W-1:0] bus;
        bus = '0;
        for (int k = 0; k < NUM_TAP; k++) begin
            bus[k*COEFF_W +: COEFF_W] = m_active[k];
        end
        return bus;
    endfunction

    function automatic logic [COEFF_W-1:0] dutTap(input int k);
        return oCoeffBus[k*COEFF_W +: COEFF_W];
    endfunction

    task automatic checkOutput(input string tag, input logic [BUS_W-1:0] observed,
                               input logic [BUS_W-1:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check this cycle's outputs, drive this cycle's inputs, advance the
    // model across the closing edge, then move to 1 ns after that edge.
    task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [COEFF_W-1:0] data, input logic commit);
        bit strobe_now;
        bit pend_pre;
        bit in_range;
        strobe_now = strobeAt(m_cycle);
        if (oEnSample === 1'b1 && m_first_strobe == 0) m_first_strobe = m_cycle;
        checkOutput("en_sample",   BUS_W'(oEnSample),   BUS_W'(strobe_now));
        checkOutput("commit_busy", BUS_W'(oCommitBusy), BUS_W'(m_pending));
        checkOutput("wr_err",      BUS_W'(oWrErr),      BUS_W'(m_err));
        checkOutput("coeff_bus",   oCoeffBus,           packActive());
        iCoeffWrEn = wr;
        iCoeffAddr = addr;
        iCoeffData = data;
        iCommit    = commit;
        pend_pre = m_pending;
        in_range = (int'(addr) < NUM_TAP);
        m_err = wr && (pend_pre || !in_range);
        if (wr && !pend_pre && in_range) m_shadow[int'(addr)] = data;
        if (pend_pre && strobe_now) begin
            for (int k = 0; k < NUM_TAP; k++) m_active[k] = m_shadow[k];
            m_pending = 0;
        end else if (!pend_pre && commit) begin
            m_pending = 1;
        end
        m_cycle++;
        @(posedge iClk_12M);
        #1;
    endtask

    task automatic doReset();
        iRsn       = 1'b0;
        iCoeffWrEn = 1'b0;
        iCoeffAddr = '0;
        iCoeffData = '0;
        iCommit    = 1'b0;
        @(posedge iClk_12M);
        #1;
        checkOutput("rst_en_sample",   BUS_W'(oEnSample),   '0);
        checkOutput("rst_commit_busy", BUS_W'(oCommitBusy), '0);
        checkOutput("rst_wr_err",      BUS_W'(oWrErr),      '0);
        checkOutput("rst_coeff_bus",   oCoeffBus,           '0);
        for (int k = 0; k < NUM_TAP; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_pending      = 0;
        m_err          = 0;
        m_cycle        = 1;
        m_first_strobe = 0;
        iRsn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic runUntilIdle();
        for (int i = 0; i < DIV + 2 && m_pending; i++) applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("commit_landed", BUS_W'(oCommitBusy), '0);
    endtask

    task automatic advanceToStrobe();
        for (int i = 0; i < DIV + 1 && !strobeAt(m_cycle); i++) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [BUS_W-1:0] exp_bus;
        int               busy_cycles;

        iRsn       = 1'b0;
        iCoeffWrEn = 1'b0;
        iCoeffAddr = '0;
        iCoeffData = '0;
        iCommit    = 1'b0;
        @(posedge iClk_12M);
        #1;

        // Reset state and strobe cadence
        doReset();
        idle(40);
        checkOutput("first_strobe_cycle", BUS_W'(m_first_strobe), BUS_W'(13));

        // Two writes then commit; bus only changes after the next strobe
        applyStimulus(1'b1, 6'd0,  16'h0100, 1'b0);
        applyStimulus(1'b1, 6'd32, 16'hFF00, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        runUntilIdle();
        checkOutput("t2_tap0",  BUS_W'(dutTap(0)),  BUS_W'(16'h0100));
        checkOutput("t2_tap32", BUS_W'(dutTap(32)), BUS_W'(16'hFF00));
        checkOutput("t2_tap1",  BUS_W'(dutTap(1)),  '0);

        // Out-of-range write is rejected and the bank stays as it was
        applyStimulus(1'b1, 6'd33, 16'h1234, 1'b0);
        checkOutput("t3_err_pulse", BUS_W'(oWrErr), BUS_W'(1'b1));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("t3_err_cleared", BUS_W'(oWrErr), '0);
        runUntilIdle();
        exp_bus = '0;
        exp_bus[0 +: COEFF_W]          = 16'h0100;
        exp_bus[32*COEFF_W +: COEFF_W] = 16'hFF00;
        checkOutput("t3_bus", oCoeffBus, exp_bus);

        // Write during a pending commit is rejected
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 6'd5, 16'h5555, 1'b0);
        checkOutput("t4_err_pulse", BUS_W'(oWrErr), BUS_W'(1'b1));
        runUntilIdle();
        checkOutput("t4_tap5", BUS_W'(dutTap(5)), '0);

        // Same-cycle write and commit: the commit carries the write
        applyStimulus(1'b1, 6'd7, 16'h8000, 1'b1);
        runUntilIdle();
        checkOutput("t5_tap7", BUS_W'(dutTap(7)), BUS_W'(16'h8000));

        // Commit in the strobe cycle waits a full period
        applyStimulus(1'b1, 6'd3, 16'h7FFF, 1'b0);
        advanceToStrobe();
        applyStimulus(1'b0, '0, '0, 1'b1);
        busy_cycles = 0;
        while (oCommitBusy === 1'b1 && busy_cycles < 4 * DIV) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
            busy_cycles++;
        end
        checkOutput("worst_latency", BUS_W'(busy_cycles), BUS_W'(DIV));
        checkOutput("lat_tap3", BUS_W'(dutTap(3)), BUS_W'(16'h7FFF));

        // Reset while a commit is pending discards it
        applyStimulus(1'b1, 6'd9, 16'hABCD, 1'b0);
        advanceToStrobe();
        idle(1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(2);
        checkOutput("t6_busy_before_rst", BUS_W'(oCommitBusy), BUS_W'(1'b1));
        doReset();
        checkOutput("t6_bus_after_rst", oCoeffBus, '0);
        idle(14);
        checkOutput("t6_first_strobe", BUS_W'(m_first_strobe), BUS_W'(13));

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                applyStimulus(($urandom_range(0, 2) == 0),
                              ADDR_W'($urandom_range(0, 40)),
                              COEFF_W'($urandom),
                              ($urandom_range(0, 7) == 0));
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
